muxn_scan: RTL and testbench

MUXN_SCAN -- requirements
Module: muxn_scan

---
 rtl/muxn_scan.sv | 95 +++++++++
 tb/tb_muxn_scan.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/muxn_scan.sv
// N-channel sampling multiplexer with a manual select mode and an automatic
// round-robin scan mode that holds each channel for a programmable dwell.
module muxn_scan #(
    parameter int SELW   = 2,
    parameter int W      = 8,
    parameter int DWELLW = 4,
    localparam int NCH   = 2 ** SELW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH*W-1:0]   datain,
    input  logic [SELW-1:0]    s,
    input  logic               mode,
    input  logic               en,
    input  logic [DWELLW-1:0]  dwell,
    output logic [W-1:0]       dataout,
    output logic [SELW-1:0]    chan,
    output logic               valid,
    output logic               wrap
);

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [SELW-1:0]    ptr, ptr_nxt;
    logic [DWELLW-1:0]  cnt, cnt_nxt;
    logic               pend, pend_nxt;
    logic [SELW-1:0]    src_p0;

    function automatic logic [W-1:0] pick(input logic [NCH*W-1:0] d,
                                          input logic [SELW-1:0]  idx);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++) begin
            if (idx == SELW'(k)) r = d[k*W +: W];
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MANUAL;
        else     state <= state_nxt;
    end

    // pend remembers a completed pass so wrap lines up with the first
    // channel-0 sample of the next pass, even across enable gaps.
    always_comb begin
        state_nxt = mode ? SCAN : MANUAL;
        src_p0    = (state == SCAN) ? ptr : s;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        if (state_nxt != state) begin
            ptr_nxt  = '0;
            cnt_nxt  = '0;
            pend_nxt = 1'b0;
        end else if (state == SCAN && en) begin
            pend_nxt = 1'b0;
            if (cnt >= dwell) begin
                cnt_nxt = '0;
                ptr_nxt = ptr + 1'b1;
                if (ptr == {SELW{1'b1}}) pend_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    // output stage: one register between sampled inputs and ports
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            cnt     <= '0;
            pend    <= 1'b0;
            dataout <= '0;
            chan    <= '0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
            valid <= en;
            wrap  <= en && (state == SCAN) && pend;
            if (en) begin
                dataout <= pick(datain, src_p0);
                chan    <= src_p0;
            end
        end
    end

endmodule

// File: tb/tb_muxn_scan.sv
// Self-checking bench for muxn_scan: vector table, dwell/reset sequences and
// randomized traffic compared against a cycle-level reference model.
module tb_muxn_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] datain;
    logic [1:0]  s;
    logic        mode;
    logic        en;
    logic [3:0]  dwell;
    logic [7:0]  dataout;
    logic [1:0]  chan;
    logic        valid;
    logic        wrap;

    int nchecks = 0;
    int nerrors = 0;

    // reference model state
    int         m_state, m_ptr, m_cnt;
    bit         m_pend;
    logic [7:0] m_dout;
    int         m_chan;
    bit         m_valid, m_wrap;

    typedef struct {
        logic       mode;
        logic       en;
        logic [1:0] s;
        logic [3:0] dwell;
        logic [7:0] edout;
        logic [1:0] echan;
        logic       evalid;
        logic       ewrap;
    } vec_t;

    vec_t tbl[$];

    muxn_scan #(.SELW(2), .W(8), .DWELLW(4)) dut (
        .clk(clk), .rst(rst), .datain(datain), .s(s), .mode(mode), .en(en),
        .dwell(dwell), .dataout(dataout), .chan(chan), .valid(valid), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return {20'd0, dataout, chan, valid, wrap};
    endfunction

    function automatic logic [31:0] pack(input logic [7:0] d, input logic [1:0] c,
                                         input logic v, input logic w);
        return {20'd0, d, c, v, w};
    endfunction

    task automatic model_reset();
        m_state = 0; m_ptr = 0; m_cnt = 0; m_pend = 0;
        m_dout = 8'h00; m_chan = 0; m_valid = 0; m_wrap = 0;
    endtask

    // One edge of behaviour derived from the rules: sample from the state in
    // effect before the edge, then update scan position, then the state.
    task automatic model_edge(input int md, input int e, input int sel, input int dw,
                              input logic [31:0] din);
        int src;
        if (e != 0) begin
            src     = (m_state == 1) ? m_ptr : sel;
            m_dout  = din[src*8 +: 8];
            m_chan  = src;
            m_valid = 1;
            m_wrap  = (m_state == 1) && m_pend;
        end else begin
            m_valid = 0;
            m_wrap  = 0;
        end
        if (md != m_state) begin
            m_ptr = 0; m_cnt = 0; m_pend = 0;
        end else if (m_state == 1 && e != 0) begin
            m_pend = 0;
            if (m_cnt >= dw) begin
                if (m_ptr == 3) m_pend = 1;
                m_ptr = (m_ptr + 1) % 4;
                m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        m_state = md;
    endtask

    task automatic step(input logic md, input logic e, input logic [1:0] sel,
                        input logic [3:0] dw);
        mode = md; en = e; s = sel; dwell = dw;
        @(posedge clk);
        model_edge(md, e, sel, dw, datain);
        #1;
        check("model", outs(), pack(m_dout, 2'(m_chan), m_valid, m_wrap));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mode = 1'b0; en = 1'b0; s = 2'd0; dwell = 4'd0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset", outs(), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        datain = 32'hDD_CC_BB_AA;
        rst = 1'b1; mode = 1'b0; en = 1'b0; s = 2'd0; dwell = 4'd0;
        model_reset();

        // manual sweep, dwell-0 scan with wrap, enable gap, mode switches
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'd0, 8'hAA, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 2'd1, 4'd0, 8'hBB, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 2'd2, 4'd0, 8'hCC, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 2'd3, 4'd0, 8'hDD, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 2'd0, 4'd0, 8'hDD, 2'd3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'd0, 4'd0, 8'hAA, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'd2, 4'd0, 8'hBB, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'd3, 4'd0, 8'hCC, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'd0, 4'd0, 8'hDD, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'd0, 4'd0, 8'hAA, 2'd0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 2'd0, 4'd0, 8'hBB, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 2'd0, 4'd0, 8'hBB, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 2'd3, 4'd0, 8'hBB, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 2'd0, 4'd0, 8'hBB, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'd0, 4'd0, 8'hCC, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'd0, 4'd0, 8'hDD, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 2'd3, 4'd0, 8'hAA, 2'd0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 2'd3, 4'd0, 8'hDD, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'd3, 4'd0, 8'hDD, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'd3, 4'd0, 8'hAA, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'd0, 4'd0, 8'hBB, 2'd1, 1'b1, 1'b0});

        #2;
        check("reset_async", outs(), 32'd0);
        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].mode, tbl[i].en, tbl[i].s, tbl[i].dwell);
            check($sformatf("vec%0d", i), outs(),
                  pack(tbl[i].edout, tbl[i].echan, tbl[i].evalid, tbl[i].ewrap));
        end

        // dwell=2: each channel held 3 cycles, wrap once per 12 cycles
        do_reset();
        step(1'b1, 1'b0, 2'd0, 4'd2);
        for (int i = 0; i < 26; i++) begin
            int c;
            c = (i / 3) % 4;
            step(1'b1, 1'b1, 2'(3 - c), 4'd2);
            check($sformatf("dwell2_%0d", i), outs(),
                  pack(8'(8'hAA + 8'h11 * c), 2'(c), 1'b1, (i >= 12) && (i % 12 == 0)));
        end

        // dwell lowered below the running count forces an advance
        do_reset();
        step(1'b1, 1'b0, 2'd0, 4'd5);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 2'd0, 4'd5);
            check("live_hold", outs(), pack(8'hAA, 2'd0, 1'b1, 1'b0));
        end
        step(1'b1, 1'b1, 2'd0, 4'd1);
        check("live_adv0", outs(), pack(8'hAA, 2'd0, 1'b1, 1'b0));
        step(1'b1, 1'b1, 2'd0, 4'd1);
        check("live_adv1", outs(), pack(8'hBB, 2'd1, 1'b1, 1'b0));
        step(1'b1, 1'b1, 2'd0, 4'd1);
        check("live_adv2", outs(), pack(8'hBB, 2'd1, 1'b1, 1'b0));
        step(1'b1, 1'b1, 2'd0, 4'd1);
        check("live_adv3", outs(), pack(8'hCC, 2'd2, 1'b1, 1'b0));

        // asynchronous reset mid-cycle, then resume from MANUAL
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_immediate", outs(), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        step(1'b1, 1'b1, 2'd2, 4'd0);
        check("rst_resume_manual", outs(), pack(8'hCC, 2'd2, 1'b1, 1'b0));
        step(1'b1, 1'b1, 2'd2, 4'd0);
        check("rst_resume_scan", outs(), pack(8'hAA, 2'd0, 1'b1, 1'b0));

        // randomized traffic against the model
        do_reset();
        begin
            logic       rm;
            logic [3:0] rd;
            rm = 1'b1;
            rd = 4'd1;
            for (int i = 0; i < 600; i++) begin
                datain = $urandom;
                if ($urandom_range(0, 15) == 0) rm = ~rm;
                if ($urandom_range(0, 7) == 0) rd = 4'($urandom_range(0, 4));
                step(rm, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rd);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
